// File: rtl/cola_pkg.sv
// Shared types and floor codes for the external call queue.
package cola_pkg;

  localparam int unsigned FLOOR_W = 2;

  typedef logic [FLOOR_W-1:0] piso_t;

  localparam piso_t PISO_MINUS_ONE = 2'b00;
  localparam piso_t PISO_ONE       = 2'b01;
  localparam piso_t PISO_TWO       = 2'b10;
  localparam piso_t PISO_THREE     = 2'b11;

endpackage

// File: rtl/cola_mem_ram.sv
// DEPTH x FLOOR_W register array: one write port, two combinational read ports, no reset.
module cola_mem_ram #(
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned FLOOR_W = cola_pkg::FLOOR_W,
  parameter int unsigned PTR_W   = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [FLOOR_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr_head,
  output logic [FLOOR_W-1:0] rdata_head,
  input  logic [PTR_W-1:0]   raddr_peek,
  output logic [FLOOR_W-1:0] rdata_peek
);

  logic [FLOOR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_head = mem[raddr_head];
  assign rdata_peek = mem[raddr_peek];

endmodule

// File: rtl/cola_llamadas_externas.sv
// FIFO of external floor calls with valid/ready pop and address-indexed peek.
// Define COLA_DEDUP_EN to drop pushes of a floor already waiting in the queue.
module cola_llamadas_externas #(
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned FLOOR_W = cola_pkg::FLOOR_W,
  parameter int unsigned PTR_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               llamada_valid,
  input  logic [FLOOR_W-1:0] llamada_piso,
  output logic               llamada_ready,
  output logic               destino_valid,
  output logic [FLOOR_W-1:0] destino,
  input  logic               destino_ready,
  input  logic [7:0]         address,
  output logic [23:0]        destino_peek,
  output logic [PTR_W:0]     count,
  output logic               lleno,
  output logic               vacio,
  output logic               desborde,
  output logic               duplicado
);

  localparam logic [PTR_W:0]   DepthCnt = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]   head_q, tail_q;
  logic [PTR_W:0]     count_q;
  logic               desborde_q;
  logic               push_ok, pop_ok, is_dup;
  logic [FLOOR_W-1:0] rd_head, rd_peek;
  logic [8:0]         peek_sum;
  logic [PTR_W-1:0]   peek_ptr;
  logic               peek_in_range;

  assign lleno         = (count_q == DepthCnt);
  assign vacio         = (count_q == '0);
  assign llamada_ready = !lleno;
  assign destino_valid = !vacio;
  assign count         = count_q;
  assign desborde      = desborde_q;

  assign pop_ok  = destino_valid && destino_ready;
  assign push_ok = llamada_valid && llamada_ready && !is_dup;

`ifdef COLA_DEDUP_EN
  localparam int unsigned NumFloors = 2 ** FLOOR_W;

  // Per-floor occupancy lets the duplicate check avoid scanning every entry.
  logic [PTR_W:0] occ_q [NumFloors];
  logic [PTR_W:0] occ_d [NumFloors];
  logic [PTR_W:0] occ_hit;
  logic           pop_same;
  logic           duplicado_q;

  assign occ_hit  = occ_q[llamada_piso];
  assign pop_same = pop_ok && (rd_head == llamada_piso);
  assign is_dup   = pop_same ? (occ_hit > (PTR_W + 1)'(1)) : (occ_hit != '0);

  always_comb begin
    for (int unsigned f = 0; f < NumFloors; f++) begin
      occ_d[f] = occ_q[f];
      if ((push_ok && llamada_piso == FLOOR_W'(f)) && !(pop_ok && rd_head == FLOOR_W'(f))) begin
        occ_d[f] = occ_q[f] + 1'b1;
      end else if (!(push_ok && llamada_piso == FLOOR_W'(f)) &&
                   (pop_ok && rd_head == FLOOR_W'(f))) begin
        occ_d[f] = occ_q[f] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned f = 0; f < NumFloors; f++) begin
        occ_q[f] <= '0;
      end
      duplicado_q <= 1'b0;
    end else begin
      for (int unsigned f = 0; f < NumFloors; f++) begin
        occ_q[f] <= occ_d[f];
      end
      duplicado_q <= llamada_valid && llamada_ready && is_dup;
    end
  end

  assign duplicado = duplicado_q;
`else
  assign is_dup    = 1'b0;
  assign duplicado = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      desborde_q <= 1'b0;
    end else begin
      if (pop_ok) begin
        head_q <= (head_q == LastPtr) ? '0 : head_q + 1'b1;
      end
      if (push_ok) begin
        tail_q <= (tail_q == LastPtr) ? '0 : tail_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (llamada_valid && lleno) begin
        desborde_q <= 1'b1;
      end
    end
  end

  // address < count <= DEPTH, so a single subtraction is enough to wrap.
  assign peek_sum      = {1'b0, address} + 9'(head_q);
  assign peek_ptr      = PTR_W'((peek_sum >= 9'(DEPTH)) ? peek_sum - 9'(DEPTH) : peek_sum);
  assign peek_in_range = (9'(address) < 9'(count_q));

  assign destino      = vacio ? '0 : rd_head;
  assign destino_peek = peek_in_range ? 24'(rd_peek) : 24'h0;

  cola_mem_ram #(
    .DEPTH  (DEPTH),
    .FLOOR_W(FLOOR_W),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk       (clk),
    .we        (push_ok),
    .waddr     (tail_q),
    .wdata     (llamada_piso),
    .raddr_head(head_q),
    .rdata_head(rd_head),
    .raddr_peek(peek_ptr),
    .rdata_peek(rd_peek)
  );

endmodule
